mix_engine: RTL and testbench

MIX_ENGINE -- requirements
Module: mix_engine

---
 rtl/mix_engine.sv | 179 +++++++++++++++++
 tb/tb_mix_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_engine.sv
// Multi-channel sample mixer: for each output sample it reads every enabled source
// channel from SDRAM, attenuates and sums it, then writes the saturated mix back.
module mix_engine #(
  parameter int NCH = 4,
  parameter int AW  = 23,
  parameter int DW  = 16,
  parameter int LW  = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              mix_start,
  input  logic [AW-1:0]     mix_dst,
  input  logic [NCH*AW-1:0] mix_src,
  input  logic [NCH-1:0]    mix_en,
  input  logic [NCH*3-1:0]  mix_shift,
  input  logic [LW-1:0]     mix_len,
  output logic              mix_busy,
  output logic              mix_done,
  output logic              mix_read,
  output logic              mix_write,
  output logic [AW-1:0]     mix_addr,
  input  logic [DW-1:0]     mix_readdata,
  output logic [DW-1:0]     mix_writedata,
  input  logic              mix_sdram_finished,
  output logic              mix_sdram_refresh
);
  localparam int ACW = DW + 4;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [ACW-1:0] ACC_MAX = ACW'(2**(DW-1) - 1);
  localparam logic signed [ACW-1:0] ACC_MIN = ACW'(-(2**(DW-1)));
  localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, GAP, RD, WR, DONE} state_t;

  state_t                  state_reg;
  logic [LW-1:0]           k_reg;
  logic [LW-1:0]           len_reg;
  logic signed [ACW-1:0]   acc_reg;
  logic [AW-1:0]           dst_reg;
  logic [NCH*AW-1:0]       src_reg;
  logic [NCH-1:0]          en_reg;
  logic [NCH*3-1:0]        shift_reg;
  logic [NCH-1:0]          visited_reg;
  logic [CW-1:0]           cur_reg;

  logic [AW-1:0]           src_arr [NCH];
  logic [2:0]              shift_arr [NCH];
  logic [NCH-1:0]          pend;
  logic                    ch_found;
  logic [CW-1:0]           ch_next;
  logic [NCH-1:0]          ch_onehot;
  logic signed [DW-1:0]    sample_shifted;
  logic signed [ACW-1:0]   acc_sum;
  logic [DW-1:0]           sat_val;
  logic [LW-1:0]           k_inc;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign src_arr[gi]   = src_reg[gi*AW +: AW];
      assign shift_arr[gi] = shift_reg[gi*3 +: 3];
    end
  endgenerate

  assign pend = en_reg & ~visited_reg;

  // Lowest-numbered enabled channel not yet read for the current sample wins.
  always_comb begin
    ch_found  = 1'b0;
    ch_next   = '0;
    ch_onehot = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pend[c]) begin
        ch_found  = 1'b1;
        ch_next   = CW'(c);
        ch_onehot = NCH'(1) << c;
      end
    end
  end

  assign sample_shifted = $signed(mix_readdata) >>> shift_arr[cur_reg];
  assign acc_sum        = acc_reg + $signed({{(ACW-DW){sample_shifted[DW-1]}}, sample_shifted});
  assign k_inc          = k_reg + 1'b1;
  assign mix_busy       = (state_reg != IDLE);

  always_comb begin
    if (acc_reg > ACC_MAX)      sat_val = OUT_MAX;
    else if (acc_reg < ACC_MIN) sat_val = OUT_MIN;
    else                        sat_val = acc_reg[DW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg         <= IDLE;
      k_reg             <= '0;
      len_reg           <= '0;
      acc_reg           <= '0;
      dst_reg           <= '0;
      src_reg           <= '0;
      en_reg            <= '0;
      shift_reg         <= '0;
      visited_reg       <= '0;
      cur_reg           <= '0;
      mix_done          <= 1'b0;
      mix_read          <= 1'b0;
      mix_write         <= 1'b0;
      mix_addr          <= '0;
      mix_writedata     <= '0;
      mix_sdram_refresh <= 1'b0;
    end else begin
      mix_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mix_start) begin
            dst_reg     <= mix_dst;
            src_reg     <= mix_src;
            en_reg      <= mix_en;
            shift_reg   <= mix_shift;
            len_reg     <= mix_len;
            k_reg       <= '0;
            acc_reg     <= '0;
            visited_reg <= '0;
            if (mix_len == '0) begin
              state_reg <= DONE;
            end else begin
              state_reg         <= GAP;
              mix_sdram_refresh <= 1'b1;
            end
          end
        end
        GAP: begin
          mix_sdram_refresh <= 1'b0;
          if (ch_found) begin
            state_reg   <= RD;
            cur_reg     <= ch_next;
            visited_reg <= visited_reg | ch_onehot;
            mix_read    <= 1'b1;
            mix_addr    <= src_arr[ch_next] + AW'(k_reg);
          end else begin
            state_reg     <= WR;
            mix_write     <= 1'b1;
            mix_addr      <= dst_reg + AW'(k_reg);
            mix_writedata <= sat_val;
          end
        end
        RD: begin
          if (mix_sdram_finished) begin
            acc_reg           <= acc_sum;
            mix_read          <= 1'b0;
            mix_addr          <= '0;
            mix_sdram_refresh <= 1'b1;
            state_reg         <= GAP;
          end
        end
        WR: begin
          if (mix_sdram_finished) begin
            mix_write     <= 1'b0;
            mix_addr      <= '0;
            mix_writedata <= '0;
            acc_reg       <= '0;
            visited_reg   <= '0;
            k_reg         <= k_inc;
            if (k_inc == len_reg) begin
              state_reg <= DONE;
            end else begin
              state_reg         <= GAP;
              mix_sdram_refresh <= 1'b1;
            end
          end
        end
        DONE: begin
          mix_done  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_engine.sv
// Bench for mix_engine: an SDRAM responder with variable latency plus a per-job
// arithmetic model of the expected read addresses and mixed output samples.
`timescale 1ns/1ps
module tb_mix_engine;
  localparam int NCH = 4;
  localparam int AW  = 23;
  localparam int DW  = 16;
  localparam int LW  = 20;
  localparam int unsigned AMASK = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mix_start;
  logic [AW-1:0]     mix_dst;
  logic [NCH*AW-1:0] mix_src;
  logic [NCH-1:0]    mix_en;
  logic [NCH*3-1:0]  mix_shift;
  logic [LW-1:0]     mix_len;
  logic              mix_busy, mix_done, mix_read, mix_write, mix_sdram_refresh;
  logic [AW-1:0]     mix_addr;
  logic [DW-1:0]     mix_readdata, mix_writedata;
  logic              mix_sdram_finished;

  mix_engine #(.NCH(NCH), .AW(AW), .DW(DW), .LW(LW)) dut (
    .i_clk(clk), .i_rst(rst_n), .mix_start(mix_start), .mix_dst(mix_dst),
    .mix_src(mix_src), .mix_en(mix_en), .mix_shift(mix_shift), .mix_len(mix_len),
    .mix_busy(mix_busy), .mix_done(mix_done), .mix_read(mix_read), .mix_write(mix_write),
    .mix_addr(mix_addr), .mix_readdata(mix_readdata), .mix_writedata(mix_writedata),
    .mix_sdram_finished(mix_sdram_finished), .mix_sdram_refresh(mix_sdram_refresh)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem [int unsigned];
  int unsigned   rd_log[$];
  int unsigned   wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  int lat_min = 0, lat_max = 0;
  int unstable_cnt = 0, proto_cnt = 0, refresh_cnt = 0, done_cnt = 0;

  function automatic logic [DW-1:0] mem_rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: acknowledges each request after a random latency and audits the bus.
  bit            sd_active = 0;
  bit            sd_prev_ref = 0;
  int            sd_cnt = 0, sd_lat = 0;
  logic [AW-1:0] sd_addr;
  bit            sd_wr;
  logic [DW-1:0] sd_data;
  initial begin
    mix_sdram_finished = 1'b0;
    mix_readdata = '0;
    forever begin
      @(negedge clk);
      mix_sdram_finished = 1'b0;
      mix_readdata = DW'($urandom);
      if (rst_n === 1'b1) begin
        if (mix_read && mix_write) proto_cnt++;
        if (mix_sdram_refresh && (mix_read || mix_write)) proto_cnt++;
        if (mix_sdram_refresh && sd_prev_ref) proto_cnt++;
        if (mix_sdram_refresh) refresh_cnt++;
        if (mix_done) done_cnt++;
        sd_prev_ref = mix_sdram_refresh;
        if (mix_read || mix_write) begin
          if (!sd_active) begin
            sd_active = 1; sd_cnt = 0; sd_lat = $urandom_range(lat_max, lat_min);
            sd_addr = mix_addr; sd_wr = mix_write; sd_data = mix_writedata;
          end else if (mix_addr !== sd_addr || mix_write !== sd_wr || mix_read !== !sd_wr ||
                       (sd_wr && mix_writedata !== sd_data)) begin
            unstable_cnt++;
          end
          if (sd_cnt >= sd_lat) begin
            mix_sdram_finished = 1'b1;
            sd_active = 0;
            if (sd_wr) begin
              mem[sd_addr] = sd_data;
              wr_addr_log.push_back(sd_addr);
              wr_data_log.push_back(sd_data);
            end else begin
              mix_readdata = mem_rd(sd_addr);
              rd_log.push_back(sd_addr);
            end
          end else begin
            sd_cnt++;
          end
        end else begin
          if (sd_active) unstable_cnt++;
          sd_active = 0;
        end
      end else begin
        sd_active = 0;
        sd_prev_ref = 0;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    unstable_cnt = 0; proto_cnt = 0; refresh_cnt = 0; done_cnt = 0;
  endtask

  task automatic fill(input int unsigned base, input int n, input logic [DW-1:0] val, input bit rnd);
    for (int i = 0; i < n; i++) mem[(base + i) & AMASK] = rnd ? DW'($urandom) : val;
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] dst, input logic [NCH*AW-1:0] src,
                         input logic [NCH-1:0] en, input logic [NCH*3-1:0] sh, input int len,
                         input bit repulse);
    int unsigned   exp_rd[$];
    int unsigned   exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    int sum, v, done_at, nen, n;
    int unsigned a;
    nen = $countones(en);
    for (int k = 0; k < len; k++) begin
      sum = 0;
      for (int c = 0; c < NCH; c++) begin
        if (en[c]) begin
          a = (int'(src[c*AW +: AW]) + k) & AMASK;
          exp_rd.push_back(a);
          v = int'($signed(mem_rd(a)));
          sum += v >>> sh[c*3 +: 3];
        end
      end
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      exp_wa.push_back((int'(dst) + k) & AMASK);
      exp_wd.push_back(DW'(sum));
    end
    @(negedge clk);
    clear_logs();
    mix_dst = dst; mix_src = src; mix_en = en; mix_shift = sh; mix_len = LW'(len);
    mix_start = 1'b1;
    done_at = -1;
    for (int i = 1; i <= 3000 && done_at < 0; i++) begin
      @(negedge clk);
      mix_start = repulse && (i == 3);
      if (repulse && i == 3) begin
        mix_dst = dst ^ 23'h5555; mix_src = ~src; mix_en = ~en; mix_len = LW'(len + 3);
      end
      if (i == 1) check({tag, " busy"}, 32'(mix_busy), 1);
      if (mix_done) done_at = i;
    end
    check({tag, " done_seen"}, 32'(done_at > 0), 1);
    if (len == 0) check({tag, " done_latency"}, done_at, 2);
    repeat (8) @(negedge clk);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " idle"}, 32'(mix_busy), 0);
    check({tag, " refresh_count"}, refresh_cnt, len * (nen + 1));
    check({tag, " protocol"}, proto_cnt, 0);
    check({tag, " stable"}, unstable_cnt, 0);
    check({tag, " reads"}, rd_log.size(), exp_rd.size());
    n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int i = 0; i < n; i++) check($sformatf("%s rd_addr[%0d]", tag, i), rd_log[i], exp_rd[i]);
    check({tag, " writes"}, wr_addr_log.size(), exp_wa.size());
    n = (wr_addr_log.size() < exp_wa.size()) ? wr_addr_log.size() : exp_wa.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s wr_addr[%0d]", tag, i), wr_addr_log[i], exp_wa[i]);
      check($sformatf("%s wr_data[%0d]", tag, i), 32'(wr_data_log[i]), 32'(exp_wd[i]));
    end
    $display("job %s: len=%0d en=%b reads=%0d writes=%0d done_at=%0d", tag, len, en,
             rd_log.size(), wr_addr_log.size(), done_at);
  endtask

  logic [NCH*AW-1:0] src;
  logic [NCH*3-1:0]  sh;
  bit                seen;

  initial begin
    rst_n = 1'b0; mix_start = 1'b0; mix_dst = '0; mix_src = '0; mix_en = '0;
    mix_shift = '0; mix_len = '0;
    repeat (3) @(negedge clk);
    check("rst read", 32'(mix_read), 0);
    check("rst write", 32'(mix_write), 0);
    check("rst refresh", 32'(mix_sdram_refresh), 0);
    check("rst busy", 32'(mix_busy), 0);
    check("rst done", 32'(mix_done), 0);
    check("rst addr", 32'(mix_addr), 0);
    check("rst wdata", 32'(mix_writedata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-channel mix of known data.
    mem[32'h1000] = 16'd100;  mem[32'h1001] = 16'd200;
    mem[32'h2000] = -16'sd50; mem[32'h2001] = 16'd50;
    src = '0; src[0*AW +: AW] = 23'h1000; src[1*AW +: AW] = 23'h2000;
    src[2*AW +: AW] = 23'h3000; src[3*AW +: AW] = 23'h4000;
    lat_min = 0; lat_max = 2;
    run_job("basic", 23'h100, src, 4'b0011, '0, 2, 0);
    if (wr_data_log.size() >= 2) begin
      check("basic sample0", 32'(wr_data_log[0]), 50);
      check("basic sample1", 32'(wr_data_log[1]), 250);
    end

    // Positive and negative saturation.
    for (int c = 0; c < NCH; c++) src[c*AW +: AW] = AW'(32'h5000 + c * 32'h100);
    for (int c = 0; c < NCH; c++) fill(32'h5000 + c * 32'h100, 1, 16'h7000, 0);
    run_job("sat_pos", 23'h6000, src, 4'b1111, '0, 1, 0);
    if (wr_data_log.size() >= 1) check("sat_pos value", 32'(wr_data_log[0]), 32'h7FFF);
    for (int c = 0; c < NCH; c++) fill(32'h5000 + c * 32'h100, 1, 16'h8000, 0);
    run_job("sat_neg", 23'h6000, src, 4'b1111, '0, 1, 0);
    if (wr_data_log.size() >= 1) check("sat_neg value", 32'(wr_data_log[0]), 32'h8000);

    // Arithmetic shift of a negative sample.
    fill(32'h5000, 1, 16'hFFF8, 0);
    sh = '0; sh[2:0] = 3'd2;
    run_job("shift", 23'h6100, src, 4'b0001, sh, 1, 0);
    if (wr_data_log.size() >= 1) check("shift value", 32'(wr_data_log[0]), 32'hFFFE);

    // Zero-length job and all-disabled job.
    run_job("len0", 23'h6200, src, 4'b1111, '0, 0, 0);
    run_job("en0", 23'h6300, src, 4'b0000, '0, 3, 0);

    // Slow SDRAM with a re-pulsed start mid-job.
    lat_min = 5; lat_max = 5;
    for (int c = 0; c < NCH; c++) fill(32'h5000 + c * 32'h100, 3, '0, 1);
    run_job("slow_restart", 23'h6400, src, 4'b1011, 12'o1234, 3, 1);

    // Address wrap at the top of the SDRAM.
    lat_min = 0; lat_max = 1;
    mem[32'h7FFFFF] = 16'd7; mem[32'h0] = 16'd9;
    src[0*AW +: AW] = 23'h7FFFFF;
    run_job("wrap", 23'h200, src, 4'b0001, '0, 2, 0);
    if (rd_log.size() >= 2) check("wrap second addr", rd_log[1], 0);

    // Randomized jobs over disjoint source regions.
    lat_min = 0; lat_max = 3;
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(5, 1);
      for (int c = 0; c < NCH; c++) begin
        src[c*AW +: AW] = AW'(32'h10000 * (c + 1) + $urandom_range(255, 0));
        fill(int'(src[c*AW +: AW]), len, '0, 1);
      end
      sh = NCH*3'($urandom);
      run_job($sformatf("rand%0d", t), AW'(32'h70000 + t * 32'h10), src, NCH'($urandom), sh, len, 0);
    end

    // Reset in the middle of a read.
    lat_min = 3; lat_max = 3;
    src[0*AW +: AW] = 23'h1000;
    @(negedge clk);
    clear_logs();
    mix_src = src; mix_en = 4'b0001; mix_shift = '0; mix_len = LW'(2); mix_dst = 23'h300;
    mix_start = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      mix_start = 1'b0;
      if (mix_read) seen = 1;
    end
    check("rst_mid read_seen", 32'(seen), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid read", 32'(mix_read), 0);
    check("rst_mid write", 32'(mix_write), 0);
    check("rst_mid refresh", 32'(mix_sdram_refresh), 0);
    check("rst_mid addr", 32'(mix_addr), 0);
    check("rst_mid wdata", 32'(mix_writedata), 0);
    check("rst_mid busy", 32'(mix_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; wr_addr_log.delete();
    repeat (20) @(negedge clk);
    check("rst_mid no_done", done_cnt, 0);
    check("rst_mid no_write", wr_addr_log.size(), 0);
    check("rst_mid idle", 32'(mix_busy), 0);
    $display("job rst_mid: reset during read, done=%0d writes=%0d", done_cnt, wr_addr_log.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
